mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_pkg.sv | 43 ++++
 rtl/alu_op_dec.sv | 25 ++
 rtl/mc_ctrl_fsm.sv | 160 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, ALU control codes,
// and the opcode/funct values the decoder recognises.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ILL    = 4'd10
  } state_t;

  // Code 3'b100 is reserved and never produced.
  localparam logic [2:0] GIN_AND   = 3'b000;
  localparam logic [2:0] GIN_OR    = 3'b001;
  localparam logic [2:0] GIN_ADD   = 3'b010;
  localparam logic [2:0] GIN_PASSA = 3'b011;
  localparam logic [2:0] GIN_SRL   = 3'b101;
  localparam logic [2:0] GIN_SUB   = 3'b110;
  localparam logic [2:0] GIN_SLT   = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_op_dec.sv
// R-type funct field to ALU control decode; valid drops for functs the
// datapath cannot execute.
module alu_op_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] gin,
  output logic       valid
);

  always_comb begin
    gin   = GIN_ADD;
    valid = 1'b1;
    case (funct)
      FN_ADD:  gin = GIN_ADD;
      FN_SUB:  gin = GIN_SUB;
      FN_AND:  gin = GIN_AND;
      FN_OR:   gin = GIN_OR;
      FN_SLT:  gin = GIN_SLT;
      FN_SRL:  gin = GIN_SRL;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore multicycle controller for a MIPS-style datapath.
// Optional feature: define BRANCH_NEG_EN to decode bltz (opcode 000001) as a branch on nout.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zout,
  input  logic       nout,
  output logic [2:0] gin,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsource,
  output logic       pc_en,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     cur;
  state_t     st;
  logic [2:0] gin_q;
  logic [2:0] dec_gin;
  logic       dec_valid;

  alu_op_dec u_alu_op_dec (
    .funct (funct),
    .gin   (dec_gin),
    .valid (dec_valid)
  );

`ifndef BRANCH_NEG_EN
  logic unused_nout;
  assign unused_nout = nout;
`endif

  // gin_q captures the EXEC operation so RWB repeats it regardless of funct.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur   <= S_FETCH;
      gin_q <= GIN_ADD;
    end else begin
      case (cur)
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     cur <= S_EXEC;
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_BEQ, OP_BNE: cur <= S_BRANCH;
            OP_J:         cur <= S_JUMP;
`ifdef BRANCH_NEG_EN
            OP_BLTZ:      cur <= S_BRANCH;
`else
            OP_BLTZ:      cur <= S_ILL;
`endif
            default:      cur <= S_ILL;
          endcase
        end
        S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  cur <= S_MEMWB;
        S_EXEC: begin
          cur   <= dec_valid ? S_RWB : S_ILL;
          gin_q <= dec_gin;
        end
        default:  cur <= S_FETCH;
      endcase
    end
  end

  assign state = cur;

  // While reset is held the outputs look like a FETCH with its side effects masked.
  always_comb begin
    st       = reset ? S_FETCH : cur;
    gin      = GIN_ADD;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    pcsource = 2'b00;
    pc_en    = 1'b0;
    illegal  = 1'b0;
    case (st)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pc_en   = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        gin     = dec_gin;
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        gin      = gin_q;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        pcsource = 2'b01;
`ifdef BRANCH_NEG_EN
        if (opcode == OP_BLTZ) begin
          gin   = GIN_PASSA;
          pc_en = nout;
        end else begin
          gin   = GIN_SUB;
          pc_en = (opcode == OP_BNE) ? ~zout : zout;
        end
`else
        gin   = GIN_SUB;
        pc_en = (opcode == OP_BNE) ? ~zout : zout;
`endif
      end
      S_JUMP: begin
        pcsource = 2'b10;
        pc_en    = 1'b1;
      end
      S_ILL:   illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      memread = 1'b0;
      irwrite = 1'b0;
      pc_en   = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction vectors with per-cycle
// expected outputs, plus reset-abort sequences.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zout;
  logic       nout;
  logic [2:0] gin;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic [1:0] pcsource;
  logic       pc_en;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // {state, gin, regwrite, memread, memwrite, pc_en, illegal, selects[8:0]}
  typedef logic [20:0] word_t;
  localparam word_t RST_W = {4'd0, 3'b010, 5'b00000, 9'b0_01_0_0_0_0_00};

  word_t exp_q[$];

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       n;
    int         cyc;
    logic [19:0] st;  // one nibble per cycle, cycle 1 leftmost
    logic [2:0] gx;   // gin from cycle 3 onward
    logic [4:0] rw;   // masks: cycle 1 is the leftmost bit
    logic [4:0] mr;
    logic [4:0] mw;
    logic [4:0] pc;
    logic [4:0] il;
  } vec_t;

  vec_t vecs[$];

  mc_ctrl_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .zout     (zout),
    .nout     (nout),
    .gin      (gin),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .iord     (iord),
    .memread  (memread),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .pcsource (pcsource),
    .pc_en    (pc_en),
    .illegal  (illegal),
    .state    (state)
  );

  always #5 clk = ~clk;

  // {alusrca, alusrcb, iord, irwrite, regdst, memtoreg, pcsource} per state
  function automatic logic [8:0] sel_exp(input logic [3:0] s);
    case (s)
      4'd0:    return 9'b0_01_0_1_0_0_00;
      4'd1:    return 9'b0_11_0_0_0_0_00;
      4'd2:    return 9'b1_10_0_0_0_0_00;
      4'd3:    return 9'b0_00_1_0_0_0_00;
      4'd4:    return 9'b0_00_0_0_0_1_00;
      4'd5:    return 9'b0_00_1_0_0_0_00;
      4'd6:    return 9'b1_00_0_0_0_0_00;
      4'd7:    return 9'b0_00_0_0_1_0_00;
      4'd8:    return 9'b1_00_0_0_0_0_01;
      4'd9:    return 9'b0_00_0_0_0_0_10;
      default: return 9'b0;
    endcase
  endfunction

  function automatic word_t obs();
    return {state, gin, regwrite, memread, memwrite, pc_en, illegal,
            alusrca, alusrcb, iord, irwrite, regdst, memtoreg, pcsource};
  endfunction

  task automatic check(input string name, input int cyc, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Entered on a falling edge with the DUT in FETCH; leaves on the falling edge of the next FETCH.
  task automatic run_vec(input vec_t v);
    logic [3:0] s;
    logic [2:0] g;
    opcode = v.op;
    funct  = v.fn;
    zout   = v.z;
    nout   = v.n;
    for (int c = 0; c < v.cyc; c++) begin
      s = v.st[19-4*c -: 4];
      g = (c < 2) ? 3'b010 : v.gx;
      exp_q.push_back({s, g, v.rw[4-c], v.mr[4-c], v.mw[4-c], v.pc[4-c], v.il[4-c], sel_exp(s)});
    end
    for (int c = 0; c < v.cyc; c++) begin
      #1;
      check(v.name, c + 1, obs(), exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  // Runs an instruction to its cycle 'at', raises reset there and checks the abort.
  task automatic abort_at(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int at, input word_t pre_exp, input word_t pre_mask);
    opcode = op;
    funct  = fn;
    zout   = 1'b0;
    nout   = 1'b0;
    repeat (at - 1) @(negedge clk);
    #1;
    check({name, "_pre"}, at, obs() & pre_mask, pre_exp);
    reset = 1'b1;
    #1;
    check({name, "_inrst"}, at, {16'd0, regwrite, memread, memwrite, pc_en, illegal}, 21'd0);
    @(negedge clk);
    check({name, "_post"}, at + 1, obs(), RST_W);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'd0;
    funct  = 6'd0;
    zout   = 1'b0;
    nout   = 1'b0;

    vecs.push_back('{"lw",     6'b100011, 6'b000000, 1'b0, 1'b0, 5, 20'h01234, 3'b010, 5'b00001, 5'b10010, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"sw",     6'b101011, 6'b000000, 1'b0, 1'b0, 4, 20'h01250, 3'b010, 5'b00000, 5'b10000, 5'b00010, 5'b10000, 5'b00000});
    vecs.push_back('{"r_add",  6'b000000, 6'b100000, 1'b0, 1'b0, 4, 20'h01670, 3'b010, 5'b00010, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"r_sub",  6'b000000, 6'b100010, 1'b0, 1'b0, 4, 20'h01670, 3'b110, 5'b00010, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"r_and",  6'b000000, 6'b100100, 1'b0, 1'b0, 4, 20'h01670, 3'b000, 5'b00010, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"r_or",   6'b000000, 6'b100101, 1'b0, 1'b0, 4, 20'h01670, 3'b001, 5'b00010, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"r_slt",  6'b000000, 6'b101010, 1'b0, 1'b0, 4, 20'h01670, 3'b111, 5'b00010, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"r_srl",  6'b000000, 6'b000010, 1'b0, 1'b0, 4, 20'h01670, 3'b101, 5'b00010, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"beq_z1", 6'b000100, 6'b000000, 1'b1, 1'b0, 3, 20'h01800, 3'b110, 5'b00000, 5'b10000, 5'b00000, 5'b10100, 5'b00000});
    vecs.push_back('{"beq_z0", 6'b000100, 6'b000000, 1'b0, 1'b0, 3, 20'h01800, 3'b110, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"bne_z1", 6'b000101, 6'b000000, 1'b1, 1'b0, 3, 20'h01800, 3'b110, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
    vecs.push_back('{"bne_z0", 6'b000101, 6'b000000, 1'b0, 1'b0, 3, 20'h01800, 3'b110, 5'b00000, 5'b10000, 5'b00000, 5'b10100, 5'b00000});
    vecs.push_back('{"j",      6'b000010, 6'b000000, 1'b0, 1'b0, 3, 20'h01900, 3'b010, 5'b00000, 5'b10000, 5'b00000, 5'b10100, 5'b00000});
    vecs.push_back('{"ill_op", 6'b111111, 6'b000000, 1'b0, 1'b0, 3, 20'h01A00, 3'b010, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00100});
    vecs.push_back('{"ill_fn", 6'b000000, 6'b111111, 1'b0, 1'b0, 4, 20'h016A0, 3'b010, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00010});
`ifdef BRANCH_NEG_EN
    vecs.push_back('{"bltz_n1", 6'b000001, 6'b000000, 1'b0, 1'b1, 3, 20'h01800, 3'b011, 5'b00000, 5'b10000, 5'b00000, 5'b10100, 5'b00000});
    vecs.push_back('{"bltz_n0", 6'b000001, 6'b000000, 1'b1, 1'b0, 3, 20'h01800, 3'b011, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00000});
`else
    vecs.push_back('{"bltz_ill", 6'b000001, 6'b000000, 1'b0, 1'b1, 3, 20'h01A00, 3'b010, 5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00100});
`endif

    repeat (2) @(negedge clk);
    check("reset", 0, obs(), RST_W);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);
    for (int k = 0; k < 24; k++) run_vec(vecs[$urandom_range(0, vecs.size() - 1)]);

    // sw aborted in MEMWR: state 5 with memwrite high before reset
    abort_at("abort_memwr", 6'b101011, 6'b000000, 4,
             {4'd5, 3'b000, 5'b00100, 9'd0}, {4'hF, 3'b000, 5'b00100, 9'd0});
    run_vec(vecs[0]);
    // R-type aborted in RWB: state 7 with regwrite high before reset
    abort_at("abort_rwb", 6'b000000, 6'b101010, 4,
             {4'd7, 3'b111, 5'b10000, 9'd0}, {4'hF, 3'b111, 5'b10000, 9'd0});
    run_vec(vecs[1]);
    // lw interrupted in MEMADR: reset overrides the MEMRD transition
    abort_at("abort_memadr", 6'b100011, 6'b000000, 3,
             {4'd2, 3'b010, 5'b00000, 9'd0}, {4'hF, 3'b111, 5'b11111, 9'd0});
    run_vec(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
